// File: rtl/beta_run_monitor_pkg.sv
// ============================================================================
// Module  : beta_run_monitor_pkg
// Brief   : Shared state encoding and default parameters for the run monitor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package beta_run_monitor_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRIME   = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam int c_DEF_PC_W        = 32;
  localparam int c_DEF_CNT_W       = 32;
  localparam int c_DEF_HALT_CYCLES = 4;
  localparam int c_DEF_MAX_CYCLES  = 1000;
  localparam int c_DEF_TRACE_DEPTH = 16;

endpackage

`default_nettype wire

// File: rtl/beta_trace_buf.sv
// ============================================================================
// Module  : beta_trace_buf
// Brief   : Circular PC trace with saturating count and registered indexed read.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module beta_trace_buf #(
  parameter int PC_W        = 32,
  parameter int TRACE_DEPTH = 16,
  localparam int c_AW       = $clog2(TRACE_DEPTH)
) (
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic            i_clr,
  input  logic            i_wr_en,
  input  logic [PC_W-1:0] i_wr_data,
  output logic [c_AW:0]   o_cnt,
  input  logic            i_rd_en,
  input  logic [c_AW-1:0] i_rd_idx,
  output logic [PC_W-1:0] o_rd_data,
  output logic            o_rd_valid
);

  localparam logic [c_AW:0] c_FULL = (c_AW+1)'(TRACE_DEPTH);

  logic [PC_W-1:0] r_mem [TRACE_DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW:0]   r_cnt;
  logic [c_AW-1:0] w_rd_addr;
  logic            w_rd_hit;

  // When full, the low count bits are zero, so the oldest entry sits at wptr.
  assign w_rd_addr = r_wptr - r_cnt[c_AW-1:0] + i_rd_idx;
  assign w_rd_hit  = ({1'b0, i_rd_idx} < r_cnt);

  always_ff @(posedge clk) begin
    if (i_wr_en && !i_clr) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr     <= '0;
      r_cnt      <= '0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      if (i_clr) begin
        r_wptr <= '0;
        r_cnt  <= '0;
      end else if (i_wr_en) begin
        r_wptr <= r_wptr + 1'b1;
        if (r_cnt != c_FULL) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= w_rd_hit ? r_mem[w_rd_addr] : '0;
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/beta_run_monitor.sv
// ============================================================================
// Module  : beta_run_monitor
// Brief   : Run control, halt/timeout detection and PC trace for the beta core.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module beta_run_monitor
  import beta_run_monitor_pkg::*;
#(
  parameter int PC_W        = c_DEF_PC_W,
  parameter int CNT_W       = c_DEF_CNT_W,
  parameter int HALT_CYCLES = c_DEF_HALT_CYCLES,
  parameter int MAX_CYCLES  = c_DEF_MAX_CYCLES,
  parameter int TRACE_DEPTH = c_DEF_TRACE_DEPTH
) (
  input  logic                           clk,
  input  logic                           RESET_N,
  input  logic                           start,
  input  logic [PC_W-1:0]                pc,
  output logic                           core_rst,
  output logic                           running,
  output logic                           done,
  output logic                           timeout,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [$clog2(TRACE_DEPTH):0]   trace_cnt,
  input  logic                           rd_en,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [PC_W-1:0]                rd_data,
  output logic                           rd_valid
);

  localparam int              c_SW        = $clog2(HALT_CYCLES);
  localparam logic [c_SW-1:0] c_HALT_LAST = c_SW'(HALT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cycle_count;
  logic [c_SW-1:0]  r_stable, w_stable_nxt;
  logic [PC_W-1:0]  r_pc_prev;
  logic             w_first, w_pc_same;
  logic             r_core_rst, r_running, r_done, r_timeout;

  // The cycle counter is zero only in the first RUN cycle after PRIME. In RUN
  // the previous PC always equals the last recorded trace entry, so one
  // compare drives both the stable counter and the trace write.
  assign w_first   = (r_state == S_RUN) && (r_cycle_count == '0);
  assign w_pc_same = !w_first && (pc == r_pc_prev);

  always_comb begin
    w_stable_nxt = w_pc_same ? r_stable + 1'b1 : '0;
    w_state_nxt  = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_PRIME;
      S_PRIME:   w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_stable_nxt == c_HALT_LAST)        w_state_nxt = S_DONE;
        else if (r_cycle_count == c_CNT_LAST)   w_state_nxt = S_TIMEOUT;
      end
      S_DONE:    if (start) w_state_nxt = S_PRIME;
      S_TIMEOUT: if (start) w_state_nxt = S_PRIME;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= S_IDLE;
      r_core_rst    <= 1'b1;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
      r_stable      <= '0;
      r_pc_prev     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_core_rst <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_PRIME);
      r_running  <= (w_state_nxt == S_RUN);
      r_done     <= (w_state_nxt == S_DONE);
      r_timeout  <= (w_state_nxt == S_TIMEOUT);
      if (w_state_nxt == S_PRIME) begin
        r_cycle_count <= '0;
        r_stable      <= '0;
      end else if (r_state == S_RUN) begin
        r_cycle_count <= r_cycle_count + 1'b1;
        r_stable      <= w_stable_nxt;
        r_pc_prev     <= pc;
      end
    end
  end

  beta_trace_buf #(
    .PC_W        (PC_W),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk        (clk),
    .i_rst_n    (RESET_N),
    .i_clr      (w_state_nxt == S_PRIME),
    .i_wr_en    ((r_state == S_RUN) && !w_pc_same),
    .i_wr_data  (pc),
    .o_cnt      (trace_cnt),
    .i_rd_en    (rd_en),
    .i_rd_idx   (rd_idx),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid)
  );

  assign core_rst    = r_core_rst;
  assign running     = r_running;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_beta_run_monitor.sv
// ============================================================================
// Module  : tb_beta_run_monitor
// Brief   : Directed self-checking bench for beta_run_monitor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_beta_run_monitor;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        start;
  logic [31:0] pc;
  logic        core_rst, running, done, timeout;
  logic [31:0] cycle_count;
  logic [4:0]  trace_cnt;
  logic        rd_en;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;
  logic        rd_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  beta_run_monitor #(
    .PC_W(32), .CNT_W(32), .HALT_CYCLES(4), .MAX_CYCLES(20), .TRACE_DEPTH(16)
  ) dut (
    .clk(clk), .RESET_N(RESET_N), .start(start), .pc(pc),
    .core_rst(core_rst), .running(running), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .trace_cnt(trace_cnt),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: 0,4,8,12 then hold; mode 1: +4 forever; mode 2: +4 until 64 at cycle 16, then hold
  function automatic logic [31:0] pc_of(input int mode, input int i);
    case (mode)
      0:       return (i < 4) ? 32'(4 * i) : 32'd12;
      1:       return 32'(4 * i);
      default: return (i <= 16) ? 32'(4 * i) : 32'd64;
    endcase
  endfunction

  task automatic do_start(input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_prime_core_rst"}, core_rst, 1);
    check({tag, "_prime_running"}, running, 0);
    check({tag, "_prime_done"}, done, 0);
    check({tag, "_prime_timeout"}, timeout, 0);
    check({tag, "_prime_cycle_count"}, cycle_count, 0);
    check({tag, "_prime_trace_cnt"}, trace_cnt, 0);
    @(negedge clk);
    check({tag, "_run_running"}, running, 1);
    check({tag, "_run_core_rst"}, core_rst, 0);
  endtask

  task automatic run_mode(input int mode, input string tag);
    int i = 0;
    while (!done && !timeout && i < 100) begin
      pc = pc_of(mode, i);
      @(negedge clk);
      i++;
    end
    check({tag, "_run_ended"}, done || timeout, 1);
  endtask

  task automatic rd_one(input int idx, input logic [31:0] exp, input string tag);
    @(negedge clk); rd_en = 1'b1; rd_idx = 4'(idx);
    @(negedge clk); rd_en = 1'b0;
    check({tag, "_rd_valid"}, rd_valid, 1);
    check({tag, "_rd_data"}, rd_data, exp);
  endtask

  // back-to-back reads of idx 0..n-1 expecting base + 4*k
  task automatic rd_seq(input int n, input int base, input string tag);
    @(negedge clk);
    rd_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      rd_idx = 4'(k);
      @(negedge clk);
      check($sformatf("%s_seq_valid%0d", tag, k), rd_valid, 1);
      check($sformatf("%s_seq_data%0d", tag, k), rd_data, 64'(base + 4 * k));
    end
    rd_en = 1'b0;
    @(negedge clk);
    check({tag, "_seq_valid_drop"}, rd_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET_N = 1'b0; start = 1'b0; pc = '0; rd_en = 1'b0; rd_idx = '0;
    repeat (3) @(negedge clk);
    RESET_N = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_core_rst", core_rst, 1);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_trace_cnt", trace_cnt, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);

    // halt after 0,4,8,12,12,12,12
    do_start("halt");
    run_mode(0, "halt");
    check("halt_done", done, 1);
    check("halt_timeout", timeout, 0);
    check("halt_running", running, 0);
    check("halt_core_rst", core_rst, 0);
    check("halt_cycle_count", cycle_count, 7);
    check("halt_trace_cnt", trace_cnt, 4);
    rd_seq(4, 0, "halt");
    rd_one(5, 32'd0, "halt_oob");
    pc = 32'd100;
    repeat (3) @(negedge clk);
    check("freeze_cycle_count", cycle_count, 7);
    check("freeze_trace_cnt", trace_cnt, 4);
    check("freeze_done", done, 1);

    // restart from DONE, then run into the budget with a wrapped trace
    do_start("tmo");
    run_mode(1, "tmo");
    check("tmo_timeout", timeout, 1);
    check("tmo_done", done, 0);
    check("tmo_cycle_count", cycle_count, 20);
    check("tmo_trace_cnt", trace_cnt, 16);
    rd_one(0, 32'd16, "tmo_idx0");
    rd_one(15, 32'd76, "tmo_idx15");
    rd_seq(16, 16, "tmo");

    // settle exactly as the budget expires: halt wins
    do_start("tie");
    run_mode(2, "tie");
    check("tie_done", done, 1);
    check("tie_timeout", timeout, 0);
    check("tie_cycle_count", cycle_count, 20);
    check("tie_trace_cnt", trace_cnt, 16);
    rd_one(0, 32'd4, "tie_idx0");
    rd_one(15, 32'd64, "tie_idx15");

    // asynchronous reset mid-run
    do_start("arst");
    for (int i = 0; i < 5; i++) begin
      pc = 32'(4 * i);
      @(negedge clk);
    end
    check("arst_pre_cycle_count", cycle_count, 5);
    #2 RESET_N = 1'b0;
    #1;
    check("arst_core_rst", core_rst, 1);
    check("arst_running", running, 0);
    check("arst_cycle_count", cycle_count, 0);
    check("arst_trace_cnt", trace_cnt, 0);
    @(negedge clk);
    RESET_N = 1'b1;
    rd_one(0, 32'd0, "arst_idx0");
    check("arst_idle_core_rst", core_rst, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
